// File: rtl/matrix_scan_if.sv
// Frame-load handshake between a frame producer and matrix_scan.
//   frame_data  : ROWS*COLS*2 bits, pixel (r,c) R at [(ROWS-1-r)*2*COLS + 2*c], G one bit above
//   frame_valid : producer offers frame_data this cycle
//   frame_ready : consumer has a free pending buffer; transfer when valid && ready
// master = producer, slave = matrix_scan.
interface matrix_scan_if #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
);
  logic [ROWS*COLS*2-1:0] frame_data;
  logic                   frame_valid;
  logic                   frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );
endinterface

// File: rtl/matrix_scan.sv
// Row-multiplexed LED matrix scanner with double-buffered frames and global PWM dimming.
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   enable       : scan enable; when low the display blanks and counters park at row 0 slot 0
//   brightness   : global dim level, sampled at each slot start
//   bus (slave)  : frame_data / frame_valid / frame_ready load handshake
//   row_o        : active-low one-hot-zero row select (registered)
//   col_r, col_g : active-high column drives for the selected row (registered)
//   frame_start  : one-cycle pulse on the pins at row 0, slot 0 (registered)
// Parameters must satisfy ROW_CYC > BLANK_CYC >= 1 and (ROW_CYC-BLANK_CYC) % 2**PWM_BITS == 0.
module matrix_scan #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned ROW_CYC   = 18,
  parameter int unsigned BLANK_CYC = 2,
  parameter int unsigned PWM_BITS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] brightness,
  matrix_scan_if.slave        bus,
  output logic [ROWS-1:0]     row_o,
  output logic [COLS-1:0]     col_r,
  output logic [COLS-1:0]     col_g,
  output logic                frame_start
);

  localparam int unsigned FrameW = ROWS * COLS * 2;
  localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SlotW  = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
  localparam int unsigned OnW    = $clog2(ROW_CYC + 1);
  localparam int unsigned Unit   = (ROW_CYC - BLANK_CYC) >> PWM_BITS;

  logic [RowW-1:0]   row_q;
  logic [SlotW-1:0]  slot_q;
  logic [FrameW-1:0] active_q;
  logic [FrameW-1:0] pending_q;
  logic              pending_full_q;
  logic [OnW-1:0]    on_len_q;

  logic [OnW-1:0]    on_len_d;
  logic              slot_last;
  logic              row_last;
  logic              boundary;
  logic              swap;
  logic              capture;
  logic              lit;
  logic [ROWS-1:0]   row_sel;
  logic [2*COLS-1:0] row_bits;
  logic [COLS-1:0]   pix_r;
  logic [COLS-1:0]   pix_g;

  // Largest product is Unit * 2**PWM_BITS == ROW_CYC-BLANK_CYC, so OnW always holds it.
  assign on_len_d  = OnW'(Unit * (32'(brightness) + 32'd1));

  assign slot_last = (32'(slot_q) == ROW_CYC - 1);
  assign row_last  = (32'(row_q) == ROWS - 1);
  assign boundary  = enable && slot_last && row_last;
  // While disabled there is no frame to tear, so a pending frame swaps in at once.
  assign swap      = pending_full_q && (boundary || !enable);
  assign capture   = bus.frame_valid && !pending_full_q;

  // Window starts at BLANK_CYC >= 1, so on_len_q latched at slot 0 is always current here.
  assign lit = enable && (32'(slot_q) >= BLANK_CYC) &&
               (32'(slot_q) < BLANK_CYC + 32'(on_len_q));

  assign bus.frame_ready = ~pending_full_q & ~rst;

  always_comb begin
    row_sel  = '1;
    row_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == RowW'(r)) begin
        row_sel[r] = 1'b0;
        row_bits   = active_q[(ROWS-1-r)*2*COLS +: 2*COLS];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      pix_r[c] = row_bits[2*c];
      pix_g[c] = row_bits[2*c+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q          <= '0;
      slot_q         <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      on_len_q       <= '0;
      row_o          <= '1;
      col_r          <= '0;
      col_g          <= '0;
      frame_start    <= 1'b0;
    end else begin
      if (!enable) begin
        row_q  <= '0;
        slot_q <= '0;
      end else if (slot_last) begin
        slot_q <= '0;
        row_q  <= row_last ? '0 : row_q + RowW'(1);
      end else begin
        slot_q <= slot_q + SlotW'(1);
      end

      if (slot_q == '0) begin
        on_len_q <= on_len_d;
      end

      // Capture needs pending empty and swap needs it full, so the two never collide.
      if (swap) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end else if (capture) begin
        pending_q      <= bus.frame_data;
        pending_full_q <= 1'b1;
      end

      row_o       <= lit ? row_sel : '1;
      col_r       <= lit ? pix_r : '0;
      col_g       <= lit ? pix_g : '0;
      frame_start <= enable && (row_q == '0) && (slot_q == '0);
    end
  end

endmodule
